// File: rtl/matrix_result_drain.sv
//==============================================================================
// Module   : matrix_result_drain
// Brief    : Snapshots a finished NxN result matrix and streams it out one
//            element per cycle over valid/ready, then pulses mm_restart.
//            Optional MATRIX_DRAIN_TRANSPOSE_EN selects column-major order.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module matrix_result_drain #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  // Flat image of matrix_c[0:N-1][0:N-1][0:W-1]: element [0][0] sits in the top W bits
  input  logic [N*N*W-1:0]       matrix_c,
  input  logic                   complete,
  output logic [W-1:0]           out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(N)-1:0]   out_row,
  output logic [$clog2(N)-1:0]   out_col,
  output logic                   out_last,
  output logic                   busy,
  output logic                   mm_restart
);

  localparam int              c_IW   = $clog2(N);
  localparam int              c_KW   = $clog2(N * N);
  localparam logic [c_IW-1:0] c_LAST = c_IW'(N - 1);
  localparam logic [c_IW-1:0] c_ONE  = c_IW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STREAM  = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_armed;
  logic [c_IW-1:0] r_row;
  logic [c_IW-1:0] r_col;
  logic [c_IW-1:0] w_row_nxt;
  logic [c_IW-1:0] w_col_nxt;
  logic [c_KW-1:0] w_idx;
  logic            w_capture;
  logic            w_xfer;
  logic            w_at_last;
  logic [W-1:0]    w_elem [N*N];
  logic [W-1:0]    r_buf  [N*N];

  genvar k;
  generate
    for (k = 0; k < N * N; k++) begin : g_unpack
      assign w_elem[k] = matrix_c[(N*N-1-k)*W +: W];

      always_ff @(posedge clock) begin
        if (w_capture) begin
          r_buf[k] <= w_elem[k];
        end
      end
    end
  endgenerate

  assign w_idx     = c_KW'(r_row) * c_KW'(N) + c_KW'(r_col);
  assign w_at_last = (r_row == c_LAST) && (r_col == c_LAST);
  assign out_row   = r_row;
  assign out_col   = r_col;
  assign out_last  = (r_state == S_STREAM) && w_at_last;
  assign busy      = (r_state != S_IDLE);

  // Index advance: the inner counter wraps at N-1 and carries into the outer one
  always_comb begin
    w_row_nxt = r_row;
    w_col_nxt = r_col;
`ifdef MATRIX_DRAIN_TRANSPOSE_EN
    if (r_row == c_LAST) begin
      w_row_nxt = '0;
      w_col_nxt = (r_col == c_LAST) ? '0 : r_col + c_ONE;
    end else begin
      w_row_nxt = r_row + c_ONE;
    end
`else
    if (r_col == c_LAST) begin
      w_col_nxt = '0;
      w_row_nxt = (r_row == c_LAST) ? '0 : r_row + c_ONE;
    end else begin
      w_col_nxt = r_col + c_ONE;
    end
`endif
  end

  always_comb begin
    w_next     = r_state;
    w_capture  = 1'b0;
    w_xfer     = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    mm_restart = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (complete && r_armed) begin
          w_capture = 1'b1;
          w_next    = S_STREAM;
        end
      end
      S_STREAM: begin
        out_valid = 1'b1;
        out_data  = r_buf[w_idx];
        w_xfer    = out_ready;
        if (out_ready && w_at_last) begin
          w_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        mm_restart = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // armed re-arms only once complete is seen low, so one assertion yields one capture
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_armed <= 1'b1;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_armed <= 1'b0;
        r_row   <= '0;
        r_col   <= '0;
      end else begin
        if (!complete) begin
          r_armed <= 1'b1;
        end
        if (w_xfer) begin
          r_row <= w_row_nxt;
          r_col <= w_col_nxt;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_matrix_result_drain.sv
//==============================================================================
// Module   : tb_matrix_result_drain
// Brief    : Directed self-checking bench for matrix_result_drain (N=4, W=8).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_matrix_result_drain;

  localparam int N = 4;
  localparam int W = 8;

  logic             clock;
  logic             reset;
  logic [N*N*W-1:0] matrix_c;
  logic             complete;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_row;
  logic [1:0]       out_col;
  logic             out_last;
  logic             busy;
  logic             mm_restart;

  int n_vec = 0;
  int n_err = 0;

  matrix_result_drain #(.N(N), .W(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .matrix_c   (matrix_c),
    .complete   (complete),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_last   (out_last),
    .busy       (busy),
    .mm_restart (mm_restart)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_matrix(input bit all_ff);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        matrix_c[(N*N-1-(i*N+j))*W +: W] = all_ff ? 8'hFF : 8'(16 * i + j);
  endtask

  // Called at the negedge where the first beat is visible. Checks every beat,
  // then the RELEASE cycle and the return to idle. abort_at >= 0 returns
  // right after checking that beat, without handshaking it.
  task automatic run_stream(input bit toggle, input int abort_at);
    int idx = 0;
    int t = 0;
    int r, c;
    bit rdy;
    while (idx < N * N && t < 200) begin
`ifdef MATRIX_DRAIN_TRANSPOSE_EN
      r = idx % N; c = idx / N;
`else
      r = idx / N; c = idx % N;
`endif
      chk("valid", out_valid, 1);
      chk("data", out_data, 16 * r + c);
      chk("row", out_row, r);
      chk("col", out_col, c);
      chk("last", out_last, idx == N * N - 1);
      chk("busy", busy, 1);
      chk("restart_in_stream", mm_restart, 0);
      if (idx == abort_at) return;
      rdy = toggle ? ((t % 4 == 0) || (t % 4 == 3)) : 1'b1;
      out_ready = rdy;
      if (rdy) idx++;
      t++;
      @(negedge clock);
    end
    n_vec++;
    assert (t < 200) else begin
      n_err++;
      $error("FAIL stream_timeout: observed %0d beats expected %0d", idx, N * N);
    end
    chk("release_restart", mm_restart, 1);
    chk("release_valid", out_valid, 0);
    chk("release_busy", busy, 1);
    @(negedge clock);
    chk("idle_restart", mm_restart, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
  endtask

  initial begin
    reset = 1'b1;
    complete = 1'b0;
    out_ready = 1'b0;
    set_matrix(1'b0);
    @(negedge clock);
    @(negedge clock);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_restart", mm_restart, 0);
    chk("rst_data", out_data, 0);
    chk("rst_row", out_row, 0);
    chk("rst_col", out_col, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_no_complete", out_valid, 0);

    // Pulsed complete, ready held high
    complete = 1'b1;
    @(negedge clock);
    complete = 1'b0;
    run_stream(1'b0, -1);

    // Pulsed complete, ready pattern 1,0,0,1
    complete = 1'b1;
    @(negedge clock);
    complete = 1'b0;
    run_stream(1'b1, -1);

    // complete held high; source bus overwritten right after capture
    complete = 1'b1;
    @(negedge clock);
    set_matrix(1'b1);
    run_stream(1'b0, -1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      chk("no_recapture", out_valid, 0);
    end
    set_matrix(1'b0);
    complete = 1'b0;
    @(negedge clock);
    chk("rearm_idle", out_valid, 0);
    complete = 1'b1;
    @(negedge clock);
    run_stream(1'b0, -1);

    // Reset on beat 7 with complete still high, then recapture from (0,0)
    complete = 1'b0;
    @(negedge clock);
    complete = 1'b1;
    @(negedge clock);
    run_stream(1'b0, 7);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_row", out_row, 0);
    chk("midrst_col", out_col, 0);
    reset = 1'b0;
    @(negedge clock);
    run_stream(1'b0, -1);
    complete = 1'b0;
    @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
